// File: rtl/foc_trace_pkg.sv
// rtl/foc_trace_pkg.sv - shared types for the FOC trace capture buffer
package foc_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TRIG_IMM    = 2'd0,
        TRIG_RISE   = 2'd1,
        TRIG_FALL   = 2'd2,
        TRIG_EITHER = 2'd3
    } trig_mode_e;

    function automatic int calc_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/foc_trace_ram.sv
// rtl/foc_trace_ram.sv - simple dual-port sample RAM with registered read
module foc_trace_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/foc_trace_buffer.sv
// rtl/foc_trace_buffer.sv - triggered multi-channel trace capture for FOC telemetry
module foc_trace_buffer
    import foc_trace_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = calc_cw(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [NUM_CH*DATA_W-1:0] i_val,
    input  logic                     cfg_arm,
    input  logic                     cfg_abort,
    input  logic [1:0]               cfg_mode,
    input  logic [CW-1:0]            cfg_trig_ch,
    input  logic [DATA_W-1:0]        cfg_level,
    input  logic [AW:0]              cfg_pre,
    input  logic [7:0]               cfg_decim,
    input  logic [AW-1:0]            rd_addr,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [2:0]               o_state
);

    localparam logic [AW:0] MAX_PRE = (AW+1)'(DEPTH - 1);

    state_e                    state, state_next;
    trig_mode_e                mode_q;
    logic [CW-1:0]             trig_ch_q;
    logic signed [DATA_W-1:0]  level_q;
    logic [AW:0]               pre_q;
    logic [7:0]                decim_q;

    logic [AW-1:0]             wr_ptr, start_ptr;
    logic [AW:0]               pre_cnt, post_cnt;
    logic [7:0]                decim_cnt;
    logic signed [DATA_W-1:0]  prev;
    logic                      prev_valid;

    logic signed [DATA_W-1:0]  cur;
    logic                      capturing, en_ok, store, hit, finish;
    logic [AW:0]               arm_pre, post_init;

    always_comb begin
        cur = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (trig_ch_q == CW'(k))
                cur = i_val[k*DATA_W +: DATA_W];
    end

    assign capturing = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
    // An i_en coinciding with arm/abort belongs to neither the old nor the new capture.
    assign en_ok     = i_en && capturing && !cfg_arm && !cfg_abort;
    assign store     = en_ok && (decim_cnt == 8'd0);
    assign arm_pre   = (cfg_pre > MAX_PRE) ? MAX_PRE : cfg_pre;
    assign post_init = MAX_PRE - pre_q;

    always_comb begin
        logic rise, fall;
        rise = prev_valid && (prev <  level_q) && (cur >= level_q);
        fall = prev_valid && (prev >= level_q) && (cur <  level_q);
        hit  = 1'b0;
        case (mode_q)
            TRIG_IMM:    hit = 1'b1;
            TRIG_RISE:   hit = rise;
            TRIG_FALL:   hit = fall;
            TRIG_EITHER: hit = rise || fall;
            default:     hit = 1'b0;
        endcase
    end

    assign finish = store && (((state == ST_WAIT) && hit && (post_init == '0)) ||
                              ((state == ST_POST) && (post_cnt == (AW+1)'(1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cfg_abort)
            state_next = ST_IDLE;
        else if (cfg_arm)
            state_next = (arm_pre == '0) ? ST_WAIT : ST_PRE;
        else if (store) begin
            case (state)
                ST_PRE:  if (pre_cnt + 1'b1 == pre_q) state_next = ST_WAIT;
                ST_WAIT: if (hit) state_next = (post_init == '0) ? ST_DONE : ST_POST;
                ST_POST: if (post_cnt == (AW+1)'(1)) state_next = ST_DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= TRIG_IMM;
            trig_ch_q  <= '0;
            level_q    <= '0;
            pre_q      <= '0;
            decim_q    <= '0;
            wr_ptr     <= '0;
            start_ptr  <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            decim_cnt  <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (cfg_abort) begin
            prev_valid <= 1'b0;
        end else if (cfg_arm) begin
            mode_q     <= trig_mode_e'(cfg_mode);
            trig_ch_q  <= cfg_trig_ch;
            level_q    <= cfg_level;
            pre_q      <= arm_pre;
            decim_q    <= cfg_decim;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            decim_cnt  <= '0;
            prev_valid <= 1'b0;
        end else if (en_ok) begin
            decim_cnt <= (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state == ST_PRE)
                    pre_cnt <= pre_cnt + 1'b1;
                if ((state == ST_PRE) || (state == ST_WAIT)) begin
                    prev       <= cur;
                    prev_valid <= 1'b1;
                end
                if ((state == ST_WAIT) && hit)
                    post_cnt <= post_init;
                if (state == ST_POST)
                    post_cnt <= post_cnt - 1'b1;
                // Oldest sample sits right after the final write once the ring is full.
                if (finish)
                    start_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    foc_trace_ram #(
        .DEPTH (DEPTH),
        .W     (NUM_CH*DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (i_val),
        .raddr (start_ptr + rd_addr),
        .rdata (rd_data)
    );

    assign o_state = state;
    assign o_busy  = capturing;
    assign o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_foc_trace_buffer.sv
// tb/tb_foc_trace_buffer.sv - directed self-checking bench for foc_trace_buffer
module tb_foc_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [63:0] i_val;
    logic        cfg_arm, cfg_abort;
    logic [1:0]  cfg_mode;
    logic [1:0]  cfg_trig_ch;
    logic [15:0] cfg_level;
    logic [4:0]  cfg_pre;
    logic [7:0]  cfg_decim;
    logic [3:0]  rd_addr;
    logic [63:0] rd_data;
    logic        o_busy, o_done;
    logic [2:0]  o_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]  addr;
        int          ch;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[$];

    foc_trace_buffer #(.NUM_CH(4), .DATA_W(16), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_val       (i_val),
        .cfg_arm     (cfg_arm),
        .cfg_abort   (cfg_abort),
        .cfg_mode    (cfg_mode),
        .cfg_trig_ch (cfg_trig_ch),
        .cfg_level   (cfg_level),
        .cfg_pre     (cfg_pre),
        .cfg_decim   (cfg_decim),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic strobe(input logic [63:0] v);
        i_en  = 1'b1;
        i_val = v;
        tick();
        i_en  = 1'b0;
    endtask

    task automatic arm(input logic [1:0] mode, input logic [1:0] ch, input int level,
                       input int pre, input int decim);
        cfg_mode    = mode;
        cfg_trig_ch = ch;
        cfg_level   = 16'(level);
        cfg_pre     = 5'(pre);
        cfg_decim   = 8'(decim);
        cfg_arm     = 1'b1;
        tick();
        cfg_arm     = 1'b0;
    endtask

    task automatic add_vec(input int addr, input int ch, input int exp);
        rd_vec_t v;
        v.addr = 4'(addr);
        v.ch   = ch;
        v.exp  = 16'(exp);
        vecs.push_back(v);
    endtask

    task automatic run_reads(input string tag);
        foreach (vecs[i]) begin
            rd_addr = vecs[i].addr;
            tick();
            tick();
            check($sformatf("%s rd[%0d] ch%0d", tag, vecs[i].addr, vecs[i].ch),
                  64'(rd_data[vecs[i].ch*16 +: 16]), 64'(vecs[i].exp));
        end
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b0; i_val = '0; cfg_arm = 1'b0; cfg_abort = 1'b0;
        cfg_mode = '0; cfg_trig_ch = '0; cfg_level = '0; cfg_pre = '0; cfg_decim = '0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 64'(o_state), 64'(0));
        check("reset busy", 64'(o_busy), 64'(0));
        check("reset done", 64'(o_done), 64'(0));
        check("reset rd_data", rd_data, 64'(0));
        rst = 1'b0;
        tick();

        // immediate trigger, pre=0
        arm(2'd0, 2'd0, 0, 0, 0);
        check("imm arm state", 64'(o_state), 64'(2));
        check("imm arm busy", 64'(o_busy), 64'(1));
        strobe(pack(0, 0, 0, 1000));
        check("imm post state", 64'(o_state), 64'(3));
        for (int k = 1; k < 15; k++) strobe(pack(k, 0, 0, 1000 + k));
        check("imm not done at 15", 64'(o_done), 64'(0));
        strobe(pack(15, 0, 0, 1015));
        check("imm done", 64'(o_done), 64'(1));
        check("imm done state", 64'(o_state), 64'(4));
        check("imm done busy", 64'(o_busy), 64'(0));
        for (int k = 0; k < 16; k++) add_vec(k, 0, k);
        add_vec(7, 3, 1007);
        run_reads("imm");

        // rising edge on ch1, level 100, pre 4
        arm(2'd1, 2'd1, 100, 4, 0);
        check("rise arm state", 64'(o_state), 64'(1));
        for (int n = 0; n < 31; n++) strobe(pack(n, 5*n, 0, 0));
        check("rise post state", 64'(o_state), 64'(3));
        strobe(pack(31, 155, 0, 0));
        check("rise done", 64'(o_done), 64'(1));
        add_vec(0, 1, 80);  add_vec(1, 1, 85);  add_vec(2, 1, 90);
        add_vec(3, 1, 95);  add_vec(4, 1, 100); add_vec(15, 1, 155);
        add_vec(4, 0, 20);
        run_reads("rise");

        // falling edge on ch2, level 0, decim 2
        arm(2'd2, 2'd2, 0, 0, 2);
        for (int n = 0; n < 57; n++) strobe(pack(0, 0, 10 - n, 0));
        check("fall post state", 64'(o_state), 64'(3));
        strobe(pack(0, 0, 10 - 57, 0));
        check("fall done", 64'(o_done), 64'(1));
        add_vec(0, 2, -2);  add_vec(1, 2, -5);
        add_vec(7, 2, -23); add_vec(15, 2, -47);
        run_reads("fall");

        // abort in POST, then simultaneous arm+abort
        arm(2'd0, 2'd0, 0, 0, 0);
        repeat (3) strobe(pack(1, 2, 3, 4));
        check("abort pre state", 64'(o_state), 64'(3));
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort busy", 64'(o_busy), 64'(0));
        check("abort done", 64'(o_done), 64'(0));
        check("abort state", 64'(o_state), 64'(0));
        arm(2'd0, 2'd0, 0, 0, 0);
        cfg_arm = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_arm = 1'b0;
        cfg_abort = 1'b0;
        check("arm+abort state", 64'(o_state), 64'(0));

        // async reset mid-POST
        arm(2'd0, 2'd0, 0, 0, 0);
        rd_addr = 4'd2;
        repeat (3) strobe(pack(9, 9, 9, 9));
        tick();
        check("rst pre state", 64'(o_state), 64'(3));
        #3 rst = 1'b1;
        #1;
        check("async rst state", 64'(o_state), 64'(0));
        check("async rst busy", 64'(o_busy), 64'(0));
        check("async rst rd_data", rd_data, 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        arm(2'd0, 2'd0, 0, 0, 0);
        for (int k = 0; k < 16; k++) strobe(pack(50 + k, 0, 0, 0));
        check("rearm done", 64'(o_done), 64'(1));
        add_vec(0, 0, 50); add_vec(9, 0, 59);
        run_reads("rearm");

        // pre clamped from 20 to 15
        arm(2'd1, 2'd0, 300, 20, 0);
        for (int n = 0; n < 30; n++) strobe(pack(10*n, 0, 0, 0));
        check("clamp wait state", 64'(o_state), 64'(2));
        strobe(pack(300, 0, 0, 0));
        check("clamp done on trigger", 64'(o_done), 64'(1));
        add_vec(15, 0, 300); add_vec(0, 0, 150); add_vec(14, 0, 290);
        run_reads("clamp");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/foc_trace_buffer.md
# foc_trace_buffer

Parametrised multi-channel capture buffer for FOC loop telemetry: id, id_aim, iq, iq_aim and any other per-period quantities. It stores one decimated sample set per control-period strobe (en_idq) into a circular RAM. Capture is triggered on a programmable level crossing with a programmable pre-trigger depth, and the frozen record is read back by logical index. It sits between the FOC core outputs and the AXI-Lite register block, replacing single-snapshot register capture with a full trace.

## Interface
Parameters:
- NUM_CH, 4, number of captured channels
- DATA_W, 16, signed sample width per channel
- DEPTH, 256, record length in sample sets; power of two, ≥4
- AW (localparam), $clog2(DEPTH), index width
- CW (localparam), max(1, $clog2(NUM_CH)), channel-select width

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- i_en  in  1  sample strobe, one cycle per control period
- i_val  in  NUM_CH*DATA_W  packed samples; channel k at [k*DATA_W +: DATA_W]
- cfg_arm  in  1  start-capture pulse
- cfg_abort  in  1  abort pulse
- cfg_mode  in  2  trigger mode: 0 immediate, 1 rising, 2 falling, 3 either edge
- cfg_trig_ch  in  CW  channel the trigger watches
- cfg_level  in  DATA_W  signed trigger level
- cfg_pre  in  AW+1  pre-trigger sample count
- cfg_decim  in  8  decimation; store every (cfg_decim+1)-th strobe
- rd_addr  in  AW  logical read index; 0 is the oldest sample
- rd_data  out  NUM_CH*DATA_W  read data
- o_busy  out  1  high in PRE, WAIT and POST
- o_done  out  1  high in DONE
- o_state  out  3  current state encoding

## Operation
- States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- cfg_arm in any state:
  - latches all cfg_* inputs and clamps pre to min(cfg_pre, DEPTH-1);
  - clears wr_ptr, pre_cnt and decim_cnt, and the prev-valid flag;
  - goes to PRE, or to WAIT when pre=0.
- cfg_abort in any state goes to IDLE. It wins over a simultaneous cfg_arm. RAM is untouched.
- Stored sample: an i_en cycle with decim_cnt==0. decim_cnt counts 0..decim on each i_en and wraps to 0. An i_en in the same cycle as cfg_arm is ignored.
- PRE: each stored sample is written at wr_ptr, then wr_ptr+1 and pre_cnt+1. When pre_cnt reaches pre the state goes to WAIT. Samples are also recorded as prev for the trigger.
- WAIT:
  - Every stored sample is written, overwriting circularly (wr_ptr wraps at DEPTH).
  - The trigger is evaluated on cur = the trig channel of this sample, against prev = the previous stored sample.
  - rising: prev < level && cur ≥ level. falling: prev ≥ level && cur < level. either: rising or falling.
  - Comparisons are signed.
  - Mode 0 triggers on the first stored sample in WAIT.
  - Without a valid prev (pre=0, first sample), modes 1-3 only prime prev.
  - On trigger: post_cnt = DEPTH-1-pre. If post_cnt is 0 go to DONE, else go to POST.
- POST: each stored sample is written and post_cnt decrements. At 0 the state goes to DONE and start_ptr is set to wr_ptr after the final write.
- Record layout: logical indices 0..pre-1 are pre-trigger, index pre is the trigger sample, and pre+1..DEPTH-1 are post-trigger.
- Read address: physical = (start_ptr + rd_addr) mod DEPTH.
  - In DONE this addresses the frozen record.
  - In other states start_ptr holds its last value.
  - Contents are valid only in DONE.
- DONE holds until cfg_arm or cfg_abort. i_en is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE, o_state 0, o_busy 0, o_done 0, rd_data 0, all pointers and counters 0.
- A reset mid-capture returns to IDLE immediately; the RAM contents are don't-care.
- State changes occur on the edge that samples the arm, abort or i_en cycle. o_busy, o_done and o_state are registered and reflect the new state after that edge.
- The RAM write happens on the same edge as the qualifying i_en.
- rd_data has 1-cycle latency: rd_addr at edge N gives data after edge N+1.
- A read of the most recently written location during capture is don't-care (no bypass).

## Structure
- Package foc_trace_pkg holds the state_e enum (3-bit), the trig_mode_e enum (2-bit) and the function computing CW.
- Sub-module foc_trace_ram: simple dual-port RAM, DEPTH x NUM_CH*DATA_W, synchronous write, registered read, no reset on the array. The read register resets to 0.
- All control logic lives in foc_trace_buffer.

## Test plan
Bench uses NUM_CH=4, DATA_W=16, DEPTH=16.
- Immediate mode, pre=0, decim=0, ch0 = 0..15 over 16 strobes → o_done after the 16th strobe; rd_addr k gives ch0=k for all k.
- Rising mode, ch1, level=100, pre=4, ch1 ramp 0,5,10,... → trigger at 100. rd_addr 0..3 = 80,85,90,95; rd_addr 4 = 100; rd_addr 15 = 155.
- Falling mode, ch2, level=0, decim=2, ch2 steps down by 1 per strobe from 10 → only every 3rd strobe is stored; the trigger sample is the first stored value <0; done after 15 further stored samples.
- Abort in POST → o_busy=0 and o_done=0 after the next edge. cfg_arm and cfg_abort in the same cycle → IDLE.
- rst asserted mid-POST → all outputs 0 asynchronously. A re-arm after release completes a normal immediate capture.
- cfg_pre=20 → clamped to 15, trigger sample at rd_addr 15, o_done on the trigger edge.
